// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared constants and types for the UART receiver, transmitter and the
//   receive-byte FIFO.
//
//   UART_DATA_W         byte width delivered by the receiver
//   UART_RX_FIFO_DEPTH  default number of entries in the receive FIFO
//   uart_byte_t         one received/transmitted byte
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-byte buffer sitting directly behind the UART receiver. Each
//   one-cycle receiver strobe is captured into a circular buffer and presented
//   to the bus side on a show-ahead valid/ready interface. Bytes arriving while
//   the buffer is full are dropped and flagged with a sticky overrun bit. A
//   level interrupt is raised while occupancy is at or above a programmable
//   threshold.
//
//   Ports
//     clk_i          system clock
//     rst_ni         asynchronous active-low reset
//     wr_valid_i     receiver byte strobe (one-cycle pulse)
//     wr_data_i      received byte, valid with wr_valid_i
//     rd_valid_o     head entry available
//     rd_data_o      head byte (show-ahead)
//     rd_ready_i     consumer accepts the head this cycle
//     flush_i        synchronous clear of contents and overrun
//     overrun_clr_i  clears the sticky overrun flag
//     thresh_i       interrupt level, 0 disables the interrupt
//     count_o        current occupancy, 0..DEPTH
//     empty_o        occupancy is zero
//     full_o         occupancy is DEPTH
//     overrun_o      sticky: at least one byte was dropped
//     irq_o          occupancy at or above a non-zero threshold
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_valid_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic                     rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    input  logic                     rd_ready_i,
    input  logic                     flush_i,
    input  logic                     overrun_clr_i,
    input  logic [$clog2(DEPTH):0]   thresh_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     overrun_o,
    output logic                     irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [DATA_W-1:0] mem [DEPTH];

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    logic overrun_q;

    logic push;
    logic pop;
    logic overrun_set;

    // The extra MSB on each pointer is a wrap bit: equal pointers mean empty,
    // equal index bits with differing wrap bits mean full.
    assign empty_o    = (wr_ptr == rd_ptr);
    assign full_o     = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_o    = wr_ptr - rd_ptr;
    assign rd_valid_o = !empty_o;
    assign rd_data_o  = mem[rd_ptr[AW-1:0]];
    assign overrun_o  = overrun_q;
    assign irq_o      = (thresh_i != '0) && (count_o >= thresh_i);

    // A full buffer still accepts a byte when the head leaves in the same cycle.
    assign pop         = rd_valid_o && rd_ready_i;
    assign push        = wr_valid_i && (!full_o || pop);
    assign overrun_set = wr_valid_i && full_o && !pop;

    // Storage is deliberately not reset; a flushed cycle's byte is never stored.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    // Flush overrides any coincident push or pop. A fresh overrun beats a
    // coincident clear so a dropped byte is never silently forgotten.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo (DEPTH 16, 8-bit bytes). A table of
//   single-cycle vectors covers ordering, thresholds and flush; hand-written
//   sequences cover overrun, push+pop at full, pointer wrap and resets.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk_i;
    logic            rst_ni;
    logic            wr_valid_i;
    uart_byte_t      wr_data_i;
    logic            rd_valid_o;
    uart_byte_t      rd_data_o;
    logic            rd_ready_i;
    logic            flush_i;
    logic            overrun_clr_i;
    logic [CW-1:0]   thresh_i;
    logic [CW-1:0]   count_o;
    logic            empty_o;
    logic            full_o;
    logic            overrun_o;
    logic            irq_o;

    int n_checks;
    int n_fails;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(UART_DATA_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wr_valid_i   (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .rd_ready_i   (rd_ready_i),
        .flush_i      (flush_i),
        .overrun_clr_i(overrun_clr_i),
        .thresh_i     (thresh_i),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .overrun_o    (overrun_o),
        .irq_o        (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          wr_valid;
        logic [7:0]    wr_data;
        logic          rd_ready;
        logic          flush;
        logic [CW-1:0] thresh;
        logic [CW-1:0] exp_count;
        logic          exp_irq;
        logic [7:0]    exp_data;
    } vec_t;

    vec_t vecs [18];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid_i    = 1'b0;
        wr_data_i     = '0;
        rd_ready_i    = 1'b0;
        flush_i       = 1'b0;
        overrun_clr_i = 1'b0;
    endtask

    task automatic apply_stimulus(input logic wv, input logic [7:0] wd,
                                  input logic rr, input logic fl, input logic oc);
        wr_valid_i    = wv;
        wr_data_i     = wd;
        rd_ready_i    = rr;
        flush_i       = fl;
        overrun_clr_i = oc;
        step();
        idle_inputs();
    endtask

    task automatic push_byte(input logic [7:0] d);
        apply_stimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp_d);
        check_output({name, " valid"}, {31'd0, rd_valid_o}, 32'd1);
        check_output({name, " data"}, {24'd0, rd_data_o}, {24'd0, exp_d});
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string name);
        check_output({name, " empty"},   {31'd0, empty_o},    32'd1);
        check_output({name, " count"},   {27'd0, count_o},    32'd0);
        check_output({name, " valid"},   {31'd0, rd_valid_o}, 32'd0);
        check_output({name, " overrun"}, {31'd0, overrun_o},  32'd0);
        check_output({name, " irq"},     {31'd0, irq_o},      32'd0);
        check_output({name, " full"},    {31'd0, full_o},     32'd0);
    endtask

    task automatic mid_cycle_reset(input string name);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check_reset_state(name);
        step();
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle_inputs();
        thresh_i = '0;
        rst_ni   = 1'b0;

        // Ordering (thresh 0)
        vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 8'h55};
        vecs[1]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 5'd0, 5'd2, 1'b0, 8'h55};
        vecs[2]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 5'd0, 5'd3, 1'b0, 8'h55};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 5'd2, 1'b0, 8'hAA};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 8'h0F};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 8'h00};
        // Threshold 4
        vecs[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 5'd4, 5'd1, 1'b0, 8'h01};
        vecs[8]  = '{1'b1, 8'h02, 1'b0, 1'b0, 5'd4, 5'd2, 1'b0, 8'h01};
        vecs[9]  = '{1'b1, 8'h03, 1'b0, 1'b0, 5'd4, 5'd3, 1'b0, 8'h01};
        vecs[10] = '{1'b1, 8'h04, 1'b0, 1'b0, 5'd4, 5'd4, 1'b1, 8'h01};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd4, 5'd3, 1'b0, 8'h02};
        vecs[12] = '{1'b1, 8'h05, 1'b1, 1'b0, 5'd4, 5'd3, 1'b0, 8'h03};
        vecs[13] = '{1'b1, 8'h06, 1'b0, 1'b0, 5'd4, 5'd4, 1'b1, 8'h03};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd4, 1'b0, 8'h03};
        // Flush with coincident push, then push+pop on empty
        vecs[15] = '{1'b1, 8'h07, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 8'h00};
        vecs[16] = '{1'b1, 8'h09, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 8'h09};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 8'h00};

        // Reset from power-up, checked while reset is held
        #12;
        check_reset_state("por");
        step();
        rst_ni = 1'b1;
        step();

        // Some traffic, then a mid-cycle reset must clear outputs immediately
        push_byte(8'h11);
        push_byte(8'h22);
        mid_cycle_reset("rst_mid1");

        for (int i = 0; i < 18; i++) begin
            thresh_i = vecs[i].thresh;
            apply_stimulus(vecs[i].wr_valid, vecs[i].wr_data, vecs[i].rd_ready,
                           vecs[i].flush, 1'b0);
            check_output($sformatf("vec%0d count", i), {27'd0, count_o},
                         {27'd0, vecs[i].exp_count});
            check_output($sformatf("vec%0d valid", i), {31'd0, rd_valid_o},
                         {31'd0, vecs[i].exp_count != 0});
            check_output($sformatf("vec%0d empty", i), {31'd0, empty_o},
                         {31'd0, vecs[i].exp_count == 0});
            check_output($sformatf("vec%0d full", i), {31'd0, full_o},
                         {31'd0, vecs[i].exp_count == 5'd16});
            check_output($sformatf("vec%0d irq", i), {31'd0, irq_o},
                         {31'd0, vecs[i].exp_irq});
            if (vecs[i].exp_count != 0) begin
                check_output($sformatf("vec%0d data", i), {24'd0, rd_data_o},
                             {24'd0, vecs[i].exp_data});
            end
        end
        thresh_i = '0;

        // Overrun: fill, drop 0xFF, drain, clear
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check_output("ovr full",  {31'd0, full_o},  32'd1);
        check_output("ovr count", {27'd0, count_o}, 32'd16);
        check_output("irq thresh0 at 16", {31'd0, irq_o}, 32'd0);
        thresh_i = 5'd16;
        #1;
        check_output("irq thresh16 at 16", {31'd0, irq_o}, 32'd1);
        thresh_i = '0;
        push_byte(8'hFF);
        check_output("ovr flag",        {31'd0, overrun_o}, 32'd1);
        check_output("ovr count stays", {27'd0, count_o},   32'd16);
        for (int i = 0; i < 16; i++) pop_check($sformatf("ovr drain%0d", i), 8'(i));
        check_output("ovr drained empty", {31'd0, empty_o},   32'd1);
        check_output("ovr sticky",        {31'd0, overrun_o}, 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_output("ovr cleared", {31'd0, overrun_o}, 32'd0);

        // Full push+pop, plus overrun set beating a coincident clear
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        check_output("ovr set wins", {31'd0, overrun_o}, 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_output("ovr clr2", {31'd0, overrun_o}, 32'd0);
        check_output("full head", {24'd0, rd_data_o}, 32'h10);
        apply_stimulus(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
        check_output("fpp count",   {27'd0, count_o},   32'd16);
        check_output("fpp overrun", {31'd0, overrun_o}, 32'd0);
        for (int i = 1; i < 16; i++) pop_check($sformatf("fpp drain%0d", i), 8'(8'h10 + i));
        pop_check("fpp last", 8'h42);
        check_output("fpp empty", {31'd0, empty_o}, 32'd1);

        // Pointer wrap: three rounds of push 10 / pop 10
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) push_byte(8'(8'h80 + r * 16 + i));
            check_output($sformatf("wrap%0d count", r), {27'd0, count_o}, 32'd10);
            for (int i = 0; i < 10; i++)
                pop_check($sformatf("wrap%0d pop%0d", r, i), 8'(8'h80 + r * 16 + i));
        end

        // Flush with count 5 and a coincident push
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        check_output("flush count", {27'd0, count_o},    32'd0);
        check_output("flush valid", {31'd0, rd_valid_o}, 32'd0);
        push_byte(8'h88);
        check_output("post flush count", {27'd0, count_o},   32'd1);
        check_output("post flush data",  {24'd0, rd_data_o}, 32'h88);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Flush also clears overrun
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push_byte(8'hFF);
        check_output("pre flush ovr", {31'd0, overrun_o}, 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_output("flush ovr", {31'd0, overrun_o}, 32'd0);
        check_output("flush empty", {31'd0, empty_o}, 32'd1);

        // Mid-operation reset with count 5
        for (int i = 0; i < 5; i++) push_byte(8'(8'hD0 + i));
        check_output("pre rst count", {27'd0, count_o}, 32'd5);
        mid_cycle_reset("rst_mid2");
        check_output("post rst count", {27'd0, count_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
